// File: rtl/mux_sel_arbiter_if.sv
// rtl/mux_sel_arbiter_if.sv - handshake bundle between sources A/B, the burst arbiter and the downstream Y port
//
// Purpose: groups the source handshakes, the mux select, the downstream
// handshake and the error flag so the arbiter and its neighbours share one port.
// Signals:
//   a_valid/a_last/a_ready   source A handshake (a_ready driven by arbiter)
//   b_valid/b_last/b_ready   source B handshake (b_ready driven by arbiter)
//   sel                      registered mux select, 0 = A, 1 = B
//   y_valid/y_ready          mux output handshake (y_valid driven by arbiter)
//   err_clr/burst_err        clear request and sticky over-length flag
// Modports: slave = arbiter side, master = sources/downstream side.

interface mux_sel_arbiter_if;
    logic a_valid;
    logic a_last;
    logic a_ready;
    logic b_valid;
    logic b_last;
    logic b_ready;
    logic sel;
    logic y_valid;
    logic y_ready;
    logic err_clr;
    logic burst_err;

    modport slave (
        input  a_valid, a_last, b_valid, b_last, y_ready, err_clr,
        output a_ready, b_ready, sel, y_valid, burst_err
    );

    modport master (
        output a_valid, a_last, b_valid, b_last, y_ready, err_clr,
        input  a_ready, b_ready, sel, y_valid, burst_err
    );
endinterface

// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - round-robin burst arbiter driving the select of a 16-bit 2:1 mux
//
// Purpose: grants source A or B for a whole burst (ended by *_last), alternates
// between sources at burst boundaries, and flags bursts longer than MAX_BURST.
// Ports:
//   clk     clock, all state on rising edge
//   rst_n   asynchronous active-low reset
//   bus     mux_sel_arbiter_if.slave: a_*/b_* source handshakes, sel,
//           y_valid/y_ready downstream handshake, err_clr, burst_err

module mux_sel_arbiter #(
    parameter int unsigned MAX_BURST    = 16,
    parameter bit          PRIO_A_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_sel_arbiter_if.slave  bus
);

    localparam int unsigned      CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ERR = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // last_grant encoding: 0 = A, 1 = B. Seeding it with B makes A win the
    // first contention, and vice versa.
    localparam logic LAST_GRANT_RST = PRIO_A_FIRST ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic             last_grant_q, last_grant_d;
    logic             burst_err_q, burst_err_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic xfer;
    logic cur_last;
    logic other_valid;
    logic err_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= 1'b0;
            last_grant_q <= LAST_GRANT_RST;
            burst_err_q  <= 1'b0;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            burst_err_q  <= burst_err_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        err_set      = 1'b0;
        cur_last     = 1'b0;
        other_valid  = 1'b0;
        bus.y_valid  = 1'b0;
        bus.a_ready  = 1'b0;
        bus.b_ready  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.a_valid && bus.b_valid) begin
                    // Contention: the source that did not own the last burst wins.
                    state_d = last_grant_q ? GNT_A : GNT_B;
                end else if (bus.a_valid) begin
                    state_d = GNT_A;
                end else if (bus.b_valid) begin
                    state_d = GNT_B;
                end
            end
            GNT_A: begin
                bus.y_valid = bus.a_valid;
                bus.a_ready = bus.y_ready;
                cur_last    = bus.a_last;
                other_valid = bus.b_valid;
            end
            GNT_B: begin
                bus.y_valid = bus.b_valid;
                bus.b_ready = bus.y_ready;
                cur_last    = bus.b_last;
                other_valid = bus.a_valid;
            end
            default: state_d = IDLE;
        endcase

        xfer = bus.y_valid & bus.y_ready;

        if (xfer) begin
            if (cur_last) begin
                last_grant_d = (state_q == GNT_B);
                beat_cnt_d   = '0;
                // Hand straight over to a waiting peer; the same source must
                // re-arbitrate through IDLE so it cannot starve the other.
                if (other_valid) begin
                    state_d = (state_q == GNT_A) ? GNT_B : GNT_A;
                end else begin
                    state_d = IDLE;
                end
            end else begin
                err_set = (beat_cnt_q == CNT_ERR);
                if (beat_cnt_q != CNT_MAX) begin
                    beat_cnt_d = beat_cnt_q + CNT_ONE;
                end
            end
        end

        // The select only moves on entry to a grant; within a burst the
        // target state equals the current one, so sel cannot toggle.
        if (state_d == GNT_A) begin
            sel_d = 1'b0;
        end else if (state_d == GNT_B) begin
            sel_d = 1'b1;
        end

        // A new violation outranks a simultaneous clear.
        burst_err_d = err_set | (burst_err_q & ~bus.err_clr);
    end

    assign bus.sel       = sel_q;
    assign bus.burst_err = burst_err_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb/tb_mux_sel_arbiter.sv - scoreboard testbench for the burst arbiter and its downstream mux

module tb_mux_sel_arbiter;

    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [15:0] a_data;
    logic [15:0] b_data;

    always #5 clk = ~clk;

    mux_sel_arbiter_if ifc();

    mux_sel_arbiter #(
        .MAX_BURST    (MAXB),
        .PRIO_A_FIRST (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];
    int          order_q[$];
    int          cur_src, must_next, last_src, beat;
    logic        exp_err, grant_due;
    logic        mon_en = 1'b0;
    logic        abort = 1'b0;
    bit          rdy_rand = 1'b0;
    bit          clr_rand = 1'b0;
    int          seq_a = 0;
    int          seq_b = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_src(input int s, input logic v, input logic l, input logic [15:0] d);
        if (s == 0) begin
            ifc.a_valid = v; ifc.a_last = l; a_data = d;
        end else begin
            ifc.b_valid = v; ifc.b_last = l; b_data = d;
        end
    endtask

    // One source: nb bursts of fixed length flen (or random 1..maxlen),
    // optional random valid gaps, and a forced 2-cycle gap before beat gap_beat.
    task automatic drive_src(input int s, input int nb, input int flen, input int maxlen,
                             input int gap_pct, input int gap_beat);
        for (int b = 0; b < nb; b++) begin
            int len;
            len = (flen > 0) ? flen : int'($urandom_range(maxlen, 1));
            for (int k = 0; k < len; k++) begin
                int g;
                int t;
                logic fired;
                logic [15:0] w;
                g = (k == gap_beat) ? 2 :
                    ((int'($urandom_range(99, 0)) < gap_pct) ? int'($urandom_range(3, 1)) : 0);
                if (g > 0) begin
                    set_src(s, 1'b0, 1'b0, 16'h0);
                    repeat (g) begin @(posedge clk); #1; end
                end
                if (s == 0) begin
                    w = {1'b0, seq_a[14:0]}; seq_a++; exp_a.push_back(w);
                end else begin
                    w = {1'b1, seq_b[14:0]}; seq_b++; exp_b.push_back(w);
                end
                set_src(s, 1'b1, (k == len - 1), w);
                t = 0;
                forever begin
                    @(negedge clk);
                    fired = (s == 0) ? (ifc.a_valid & ifc.a_ready) : (ifc.b_valid & ifc.b_ready);
                    @(posedge clk); #1;
                    if (abort) begin
                        set_src(s, 1'b0, 1'b0, 16'h0);
                        return;
                    end
                    if (fired) break;
                    t++;
                    if (t > 500) begin
                        chk("source_accept_timeout", 32'd1, 32'd0);
                        break;
                    end
                end
            end
        end
        set_src(s, 1'b0, 1'b0, 16'h0);
    endtask

    // Reference rules: per-source FIFO order, bursts never interleaved,
    // handover to a waiting peer, round-robin on contention, 1-cycle grant
    // latency, and burst_err raised on the MAXB-th beat of a non-ending burst.
    task automatic mon_step();
        logic fa, fb, xfer, lst, oth, ended, set;
        int src;
        logic [15:0] yd, ew;
        fa    = ifc.a_valid & ifc.a_ready;
        fb    = ifc.b_valid & ifc.b_ready;
        xfer  = ifc.y_valid & ifc.y_ready;
        ended = 1'b0;
        set   = 1'b0;
        chk("burst_err", ifc.burst_err, exp_err);
        if (grant_due) begin
            chk("grant_y_valid", ifc.y_valid, 1);
            chk("grant_sel", ifc.sel, must_next);
            grant_due = 1'b0;
        end
        if (!ifc.y_ready) chk("stall_readies", fa | fb | ifc.a_ready | ifc.b_ready, 0);
        if (cur_src < 0 && must_next < 0) chk("idle_y_valid", ifc.y_valid, 0);
        if (xfer) begin
            chk("xfer_single_ready", fa ^ fb, 1);
            src = fb ? 1 : 0;
            chk("xfer_sel", ifc.sel, src);
            yd = ifc.sel ? b_data : a_data;
            if ((src == 0 && exp_a.size() == 0) || (src == 1 && exp_b.size() == 0)) begin
                chk("queue_underflow", 32'd1, 32'd0);
            end else begin
                ew = (src == 0) ? exp_a.pop_front() : exp_b.pop_front();
                chk("y_data", yd, ew);
            end
            lst = (src == 0) ? ifc.a_last : ifc.b_last;
            if (cur_src < 0) begin
                if (must_next >= 0) chk("grant_src", src, must_next);
                order_q.push_back(src);
                cur_src   = src;
                beat      = 0;
                must_next = -1;
            end else begin
                chk("burst_hold", src, cur_src);
            end
            beat++;
            set = !lst && (beat == MAXB);
            if (lst) begin
                ended    = 1'b1;
                last_src = src;
                cur_src  = -1;
                oth      = (src == 0) ? ifc.b_valid : ifc.a_valid;
                if (oth) begin
                    must_next = 1 - src;
                    grant_due = 1'b1;
                end
            end
        end else begin
            chk("ready_without_xfer", fa | fb, 0);
        end
        exp_err = set ? 1'b1 : (ifc.err_clr ? 1'b0 : exp_err);
        if (!ended && cur_src < 0 && must_next < 0 && (ifc.a_valid || ifc.b_valid)) begin
            if (ifc.a_valid && ifc.b_valid) must_next = 1 - last_src;
            else must_next = ifc.a_valid ? 0 : 1;
            grant_due = 1'b1;
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (mon_en) mon_step();
        end
    endtask

    task automatic stim_gen();
        forever begin
            @(posedge clk); #1;
            if (rdy_rand) ifc.y_ready = (int'($urandom_range(99, 0)) < 70);
            if (clr_rand) ifc.err_clr = (int'($urandom_range(99, 0)) < 5);
        end
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        exp_a.delete(); exp_b.delete(); order_q.delete();
        cur_src = -1; must_next = -1; last_src = 1; beat = 0;
        exp_err = 1'b0; grant_due = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic apply_reset();
        mon_en = 1'b0;
        rst_n  = 1'b0;
        set_src(0, 1'b0, 1'b0, 16'h0);
        set_src(1, 1'b0, 1'b0, 16'h0);
        ifc.y_ready = 1'b0;
        ifc.err_clr = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        release_reset();
    endtask

    task automatic wait_fires(input int s, input int n);
        int f;
        int t;
        f = 0; t = 0;
        while (f < n && t < 200) begin
            @(negedge clk);
            if (s == 0 ? (ifc.a_valid & ifc.a_ready) : (ifc.b_valid & ifc.b_ready)) f++;
            t++;
        end
        if (f < n) chk("wait_fires_timeout", f, n);
        @(posedge clk); #1;
    endtask

    task automatic settle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst_n = 1'b0;
        set_src(0, 1'b1, 1'b0, 16'h0);
        set_src(1, 1'b1, 1'b0, 16'h8000);
        ifc.y_ready = 1'b1;
        ifc.err_clr = 1'b0;
        fork
            monitor();
            stim_gen();
            begin
                #500000;
                $display("FAIL watchdog: simulation did not complete in time");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset values, with both sources requesting to prove nothing leaks.
        settle(2);
        chk("rst_sel", ifc.sel, 0);
        chk("rst_y_valid", ifc.y_valid, 0);
        chk("rst_a_ready", ifc.a_ready, 0);
        chk("rst_b_ready", ifc.b_ready, 0);
        chk("rst_burst_err", ifc.burst_err, 0);

        // Single A burst of 3 beats.
        apply_reset();
        ifc.y_ready = 1'b1;
        drive_src(0, 1, 3, 0, 0, -1);
        settle(3);
        chk("t1_bursts", order_q.size(), 1);
        chk("t1_src", order_q[0], 0);
        chk("t1_drained", exp_a.size(), 0);

        // Continuous contention, bursts of 2: A,B,A,B,A,B with no bubbles.
        apply_reset();
        ifc.y_ready = 1'b1;
        fork
            drive_src(0, 3, 2, 0, 0, -1);
            drive_src(1, 3, 2, 0, 0, -1);
        join
        settle(3);
        chk("t2_bursts", order_q.size(), 6);
        for (int i = 0; i < 6 && i < order_q.size(); i++) chk("t2_order", order_q[i], i % 2);

        // Downstream stall for 5 cycles in the middle of a 4-beat A burst.
        apply_reset();
        ifc.y_ready = 1'b1;
        fork
            drive_src(0, 1, 4, 0, 0, -1);
            begin
                wait_fires(0, 2);
                ifc.y_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("t3_a_ready", ifc.a_ready, 0);
                    chk("t3_sel", ifc.sel, 0);
                    chk("t3_y_valid", ifc.y_valid, 1);
                end
                @(posedge clk); #1;
                ifc.y_ready = 1'b1;
            end
        join
        settle(3);
        chk("t3_no_err", ifc.burst_err, 0);
        chk("t3_drained", exp_a.size(), 0);

        // Over-length burst, clear, then clear colliding with a new violation.
        apply_reset();
        ifc.y_ready = 1'b1;
        drive_src(0, 1, 6, 0, 0, -1);
        settle(2);
        chk("t4_err_set", ifc.burst_err, 1);
        ifc.err_clr = 1'b1;
        settle(1);
        ifc.err_clr = 1'b0;
        chk("t4_err_clr", ifc.burst_err, 0);
        fork
            drive_src(0, 1, 5, 0, 0, -1);
            begin
                wait_fires(0, 3);
                ifc.err_clr = 1'b1;
                settle(1);
                ifc.err_clr = 1'b0;
            end
        join
        settle(2);
        chk("t4_set_wins", ifc.burst_err, 1);

        // Asynchronous reset in the middle of a B burst.
        apply_reset();
        ifc.y_ready = 1'b1;
        fork
            drive_src(1, 1, 6, 0, 0, -1);
        join_none
        wait_fires(1, 2);
        #3;
        mon_en = 1'b0;
        abort  = 1'b1;
        rst_n  = 1'b0;
        #1;
        chk("t5_sel", ifc.sel, 0);
        chk("t5_y_valid", ifc.y_valid, 0);
        chk("t5_a_ready", ifc.a_ready, 0);
        chk("t5_b_ready", ifc.b_ready, 0);
        settle(3);
        abort = 1'b0;
        release_reset();
        fork
            drive_src(0, 1, 2, 0, 0, -1);
            drive_src(1, 1, 2, 0, 0, -1);
        join
        settle(3);
        chk("t5_bursts", order_q.size(), 2);
        chk("t5_first_is_a", order_q[0], 0);

        // B drops valid mid-burst while A waits: no switch until B's last.
        apply_reset();
        ifc.y_ready = 1'b1;
        fork
            drive_src(1, 1, 4, 0, 0, 2);
            begin
                settle(2);
                drive_src(0, 1, 2, 0, 0, -1);
            end
        join
        settle(3);
        chk("t6_bursts", order_q.size(), 2);
        chk("t6_first_b", order_q[0], 1);
        chk("t6_then_a", order_q[1], 0);

        // Randomised traffic: gaps, stalls, over-length bursts, random clears.
        apply_reset();
        rdy_rand = 1'b1;
        clr_rand = 1'b1;
        fork
            drive_src(0, 12, 0, 6, 30, -1);
            drive_src(1, 12, 0, 6, 30, -1);
        join
        rdy_rand = 1'b0;
        clr_rand = 1'b0;
        settle(1);
        ifc.err_clr = 1'b0;
        settle(3);
        chk("rand_drained_a", exp_a.size(), 0);
        chk("rand_drained_b", exp_b.size(), 0);
        chk("rand_bursts", order_q.size(), 24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
